acc_adder_tree: RTL and testbench

ACC_ADDER_TREE -- requirements
Module: acc_adder_tree

---
 rtl/adder_pkg.sv | 49 ++++
 rtl/adder_tree_level.sv | 46 ++++
 rtl/acc_adder_tree.sv | 118 +++++++++++
 tb/tb_acc_adder_tree.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the accumulating adder tree: tree depth and per-level
// element counts, and the signed saturate/overflow step applied to each result.
package adder_pkg;

   // Widest accumulator value the result stage handles.
   localparam int unsigned MAX_W = 64;

   typedef struct packed {
      logic signed [MAX_W-1:0] sum;
      logic                    ovf;
   } result_t;

   // Number of registered tree levels: clog2(n), but never fewer than one.
   function automatic int tree_levels(input int n);
      int s;
      s = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) s = i + 1;
      end
      if (s < 1) s = 1;
      return s;
   endfunction

   // Element count presented to level k (level 0 sees the raw beat).
   function automatic int level_count(input int n, input int k);
      int c;
      c = n;
      for (int i = 0; i < k; i++) c = (c + 1) / 2;
      return c;
   endfunction

   // Range-checks val against a signed out_w-bit window. The caller keeps the
   // low out_w bits of sum: either the clamped value or the plain truncation.
   function automatic result_t sat_result(input logic signed [MAX_W-1:0] val,
                                          input int                      out_w,
                                          input logic                    sat_en);
      result_t                 r;
      logic signed [MAX_W-1:0] max_v;
      logic signed [MAX_W-1:0] min_v;
      max_v = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
      min_v = ~max_v;
      r.ovf = (val > max_v) || (val < min_v);
      r.sum = val;
      if (sat_en && (val > max_v)) r.sum = max_v;
      if (sat_en && (val < min_v)) r.sum = min_v;
      return r;
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: adds neighbouring signed elements in
// pairs, widening by one bit; an unpaired last element is carried through.
module adder_tree_level #(
   parameter  int pIN_NUM    = 2,
   parameter  int pIN_WIDTH  = 8,
   localparam int pOUT_NUM   = (pIN_NUM + 1) / 2,
   localparam int pOUT_WIDTH = pIN_WIDTH + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           advance,
   input  logic                           in_valid,
   input  logic                           in_last,
   input  logic [pIN_NUM*pIN_WIDTH-1:0]   data_in,
   output logic                           out_valid,
   output logic                           out_last,
   output logic [pOUT_NUM*pOUT_WIDTH-1:0] data_out
);

   logic [pOUT_NUM*pOUT_WIDTH-1:0] sum_c;

   for (genvar i = 0; i < pOUT_NUM; i++) begin : g_pair
      if (2*i + 1 < pIN_NUM) begin : g_add
         assign sum_c[i*pOUT_WIDTH +: pOUT_WIDTH] =
            pOUT_WIDTH'($signed(data_in[(2*i)*pIN_WIDTH +: pIN_WIDTH])) +
            pOUT_WIDTH'($signed(data_in[(2*i+1)*pIN_WIDTH +: pIN_WIDTH]));
      end else begin : g_pass
         assign sum_c[i*pOUT_WIDTH +: pOUT_WIDTH] =
            pOUT_WIDTH'($signed(data_in[(2*i)*pIN_WIDTH +: pIN_WIDTH]));
      end
   end

   // Level register with its valid/last sideband; frozen while the pipe stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         data_out  <= '0;
      end else if (advance) begin
         out_valid <= in_valid;
         out_last  <= in_last;
         data_out  <= sum_c;
      end
   end

endmodule

// File: rtl/acc_adder_tree.sv
// Reduces each beat of pINPUT_NUM signed elements through a registered adder
// tree, accumulates tree sums across a group, and emits one saturated or
// truncated result per group with an overflow flag.
module acc_adder_tree #(
   parameter int pDATA_WIDTH = 16,
   parameter int pINPUT_NUM  = 32,
   parameter int pACC_WIDTH  = 40,
   parameter int pOUT_WIDTH  = 32,
   parameter int pSAT_EN     = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_last,
   input  logic [pDATA_WIDTH*pINPUT_NUM-1:0] data_in,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [pOUT_WIDTH-1:0]             data_out,
   output logic                              out_ovf
);

   import adder_pkg::*;

   localparam int S      = tree_levels(pINPUT_NUM);
   localparam int TREE_W = pDATA_WIDTH + S;

   logic                         advance;
   logic [TREE_W-1:0]            tree_sum;
   logic                         tree_valid;
   logic                         tree_last;
   logic signed [pACC_WIDTH-1:0] acc;
   logic signed [pACC_WIDTH-1:0] acc_next;
   result_t                      res;

   // A pending result that is not being taken freezes the whole pipe.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < S; k++) begin : g_lvl
      localparam int NI = level_count(pINPUT_NUM, k);
      localparam int NO = level_count(pINPUT_NUM, k + 1);
      localparam int WI = pDATA_WIDTH + k;

      logic [NI*WI-1:0]     lvl_in;
      logic                 lvl_in_valid;
      logic                 lvl_in_last;
      logic [NO*(WI+1)-1:0] lvl_out;
      logic                 lvl_out_valid;
      logic                 lvl_out_last;

      if (k == 0) begin : g_src
         assign lvl_in       = data_in;
         assign lvl_in_valid = in_valid;
         assign lvl_in_last  = in_last;
      end else begin : g_chain
         assign lvl_in       = g_lvl[k-1].lvl_out;
         assign lvl_in_valid = g_lvl[k-1].lvl_out_valid;
         assign lvl_in_last  = g_lvl[k-1].lvl_out_last;
      end

      adder_tree_level #(
         .pIN_NUM   (NI),
         .pIN_WIDTH (WI)
      ) u_level (
         .clk       (clk),
         .rst       (rst),
         .advance   (advance),
         .in_valid  (lvl_in_valid),
         .in_last   (lvl_in_last),
         .data_in   (lvl_in),
         .out_valid (lvl_out_valid),
         .out_last  (lvl_out_last),
         .data_out  (lvl_out)
      );

      if (k == S - 1) begin : g_root
         assign tree_sum   = lvl_out;
         assign tree_valid = lvl_out_valid;
         assign tree_last  = lvl_out_last;
      end
   end

   assign acc_next = acc + pACC_WIDTH'($signed(tree_sum));

   // Range check of the closing group sum against the output width.
   always_comb begin
      res = sat_result(MAX_W'(acc_next), pOUT_WIDTH, pSAT_EN != 0);
   end

   if (pOUT_WIDTH < MAX_W) begin : g_res_hi
      logic unused_res_hi;
      assign unused_res_hi = ^res.sum[MAX_W-1:pOUT_WIDTH];
   end

   // Accumulate non-last tree sums; a last sum publishes the result and restarts.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (advance && tree_valid) begin
            if (tree_last) begin
               data_out  <= res.sum[pOUT_WIDTH-1:0];
               out_ovf   <= res.ovf;
               out_valid <= 1'b1;
               acc       <= '0;
            end else begin
               acc <= acc_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_acc_adder_tree.sv
// Drives identical beats into three configurations (16-bit out, 8-bit
// saturating, 8-bit truncating); a scoreboard queue of hand-computed group
// sums is consumed by a monitor that checks each presented result.
module tb_acc_adder_tree;

   localparam int DW  = 8;
   localparam int NIN = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic              out_ready = 1'b1;
   logic [NIN*DW-1:0] data_in = '0;

   logic        ir0, ir1, ir2;
   logic        ov0, ov1, ov2;
   logic        of0, of1, of2;
   logic [15:0] dout0;
   logic [7:0]  dout1, dout2;

   logic irv[3];
   logic ovv[3];
   logic ofv[3];
   int   act[3];

   typedef struct {
      int sum;
      int cyc;
      bit lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   rd[3];
   bit   new_res[3];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   acc_adder_tree #(.pDATA_WIDTH(DW), .pINPUT_NUM(NIN), .pACC_WIDTH(40),
                    .pOUT_WIDTH(16), .pSAT_EN(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .in_last(in_last), .data_in(data_in), .out_valid(ov0),
      .out_ready(out_ready), .data_out(dout0), .out_ovf(of0));

   acc_adder_tree #(.pDATA_WIDTH(DW), .pINPUT_NUM(NIN), .pACC_WIDTH(40),
                    .pOUT_WIDTH(8), .pSAT_EN(1)) u_sat8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
      .in_last(in_last), .data_in(data_in), .out_valid(ov1),
      .out_ready(out_ready), .data_out(dout1), .out_ovf(of1));

   acc_adder_tree #(.pDATA_WIDTH(DW), .pINPUT_NUM(NIN), .pACC_WIDTH(40),
                    .pOUT_WIDTH(8), .pSAT_EN(0)) u_trc8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
      .in_last(in_last), .data_in(data_in), .out_valid(ov2),
      .out_ready(out_ready), .data_out(dout2), .out_ovf(of2));

   always_comb begin
      irv[0] = ir0; irv[1] = ir1; irv[2] = ir2;
      ovv[0] = ov0; ovv[1] = ov1; ovv[2] = ov2;
      ofv[0] = of0; ofv[1] = of1; ofv[2] = of2;
      act[0] = int'($signed(dout0));
      act[1] = int'($signed(dout1));
      act[2] = int'($signed(dout2));
   end

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      logic [7:0] ea, eb, ec, ed;
      ea = a[7:0]; eb = b[7:0]; ec = c[7:0]; ed = d[7:0];
      return {ed, ec, eb, ea};
   endfunction

   // Expected data_out per configuration from the true group sum.
   function automatic int exp_data(input int d, input int s);
      logic [7:0] lo;
      if (d == 0) return s;
      if (d == 1) return (s > 127) ? 127 : ((s < -128) ? -128 : s);
      lo = s[7:0];
      return int'($signed(lo));
   endfunction

   function automatic int exp_ovf(input int d, input int s);
      if (d == 0) return (s > 32767 || s < -32768) ? 1 : 0;
      return (s > 127 || s < -128) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, a, e, $time);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [31:0] d, input logic last, input int sum, input bit lat);
      int n;
      n = 0;
      in_valid = 1'b1;
      data_in  = d;
      in_last  = last;
      #1;
      while (!ir0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 60) begin
         checks++;
         failures++;
         $display("FAIL send_timeout in_ready=%0d required=1", ir0);
      end else if (last) begin
         exp_q.push_back('{sum: sum, cyc: cyc, lat: lat});
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rd[0] != exp_q.size() || rd[1] != exp_q.size() || rd[2] != exp_q.size())
             && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size() - rd[0]);
      end
      @(negedge clk);
   endtask

   // Monitor: compare every presented result with the queue head; pop on handshake.
   always begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 3; d++) begin
         if (!rst) begin
            new_res[d] = 1'b1;
         end else begin
            if (ovv[d]) begin
               if (rd[d] >= exp_q.size()) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_result dut=%0d data=%0d required=none", d, act[d]);
               end else begin
                  mon_e = exp_q[rd[d]];
                  if (new_res[d] && mon_e.lat)
                     chk($sformatf("latency_dut%0d_res%0d", d, rd[d]), cyc - mon_e.cyc, 3);
                  chk($sformatf("data_dut%0d_res%0d", d, rd[d]), act[d], exp_data(d, mon_e.sum));
                  chk($sformatf("ovf_dut%0d_res%0d", d, rd[d]), int'(ofv[d]), exp_ovf(d, mon_e.sum));
                  if (!out_ready)
                     chk($sformatf("stall_in_ready_dut%0d", d), int'(irv[d]), 0);
                  else
                     rd[d]++;
               end
            end
            new_res[d] = !ovv[d] || out_ready;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout time=%0t required=finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rd[d] = 0;
         new_res[d] = 1'b1;
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset_out_valid", int'(ov0), 0);
      chk("reset_data_out", act[0], 0);
      chk("reset_out_ovf", int'(of0), 0);
      chk("reset_in_ready", int'(ir0), 1);
      @(negedge clk);

      // Single-beat groups, latency checked.
      send(pk(1, 2, 3, 4), 1'b1, 10, 1'b1);
      drain();
      send(pk(-128, -128, -128, -128), 1'b1, -512, 1'b1);
      send(pk(127, -1, 0, 5), 1'b1, 131, 1'b1);
      drain();

      // Multi-beat group, then a group that must start from a cleared acc.
      send(pk(1, 1, 1, 1), 1'b0, 0, 1'b0);
      send(pk(1, 1, 1, 1), 1'b0, 0, 1'b0);
      send(pk(1, 1, 1, 1), 1'b1, 12, 1'b1);
      send(pk(2, 2, 2, 2), 1'b1, 8, 1'b1);
      drain();

      // Overflow of the 8-bit outputs.
      send(pk(100, 100, 100, 100), 1'b1, 400, 1'b1);
      drain();

      // Downstream stall with results in flight.
      out_ready = 1'b0;
      fork
         begin
            send(pk(1, 2, 3, 4), 1'b1, 10, 1'b1);
            send(pk(5, 5, 5, 5), 1'b1, 20, 1'b0);
            send(pk(-1, -1, -1, -1), 1'b1, -4, 1'b0);
            send(pk(7, 7, 7, 7), 1'b1, 28, 1'b0);
         end
         begin
            int n = 0;
            while (!ov0 && n < 50) begin
               @(negedge clk);
               n++;
            end
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a group discards it.
      send(pk(1, 1, 1, 1), 1'b0, 0, 1'b0);
      send(pk(1, 1, 1, 1), 1'b0, 0, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midreset_out_valid", int'(ov0), 0);
      chk("midreset_in_ready", int'(ir0), 1);
      @(negedge clk);
      send(pk(1, 0, 0, 0), 1'b1, 1, 1'b1);
      drain();

      // Back-to-back single-beat groups: one result per cycle.
      send(pk(3, -3, 7, 0), 1'b1, 7, 1'b1);
      send(pk(-5, -6, -7, -8), 1'b1, -26, 1'b1);
      send(pk(50, 60, 70, 80), 1'b1, 260, 1'b1);
      send(pk(-100, -100, -100, 27), 1'b1, -273, 1'b1);
      drain();

      repeat (4) @(negedge clk);
      for (int d = 0; d < 3; d++)
         chk($sformatf("results_consumed_dut%0d", d), rd[d], exp_q.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
